seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: W, default 8, operand/result width; legal W >= 4, power of two.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- A  in  W  operand A.
- B  in  W  operand B; shift amount is B[$clog2(W)-1:0].
- CONTROL  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- C  out  W  result.
- N, Z, CO, OVF  out  1 each  registered flags of the last completed operation.
- ERR  out  1  last completed opcode was reserved.

Function
REQ-003 Opcodes: 0 ADD; 1 SUB A-B; 2 SUB B-A; 3 BTC (A & ~B); 4 AND; 5 OR; 6 XOR; 7 XNOR; 8 LSL; 9 LSR; 10 ASR; 11 MUL; 12 ADC (A+B+CO); 13 SBC (A+~B+CO); 14-15 reserved.
REQ-004 Handshake: a request is accepted on a rising edge with in_valid && in_ready; A, B and CONTROL are captured at that edge.
REQ-005 Result transfer: completes on an edge with out_valid && out_ready.
REQ-006 FSM states are IDLE, BUSY and OUT; in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-007 Transitions:
- IDLE -> OUT on accept of a non-MUL opcode.
- IDLE -> BUSY on accept of MUL.
- BUSY -> OUT after exactly W cycles in BUSY.
- OUT -> IDLE on result transfer.
- OUT holds C, flags and ERR stable while out_ready = 0.
REQ-008 Latency: out_valid first high in the cycle after accept for non-MUL opcodes, and W+1 cycles after accept for MUL.
REQ-009 MUL: radix-2 shift-add, unsigned, one partial-product step per BUSY cycle; C = low W bits of the product.
REQ-010 N, Z and CO/OVF for ADD, SUB, ADC and SBC:
- N = C[W-1]; Z = (C == 0).
- CO = carry-out of the W-bit addition; subtraction is computed as X + ~Y + 1, so CO = 1 means no borrow.
- OVF = signed overflow (operand signs equal and result sign differs, using the effective operands).
REQ-011 Logic opcodes 3-7: CO = 0, OVF = 0.
REQ-012 Shifts:
- CO = last bit shifted out; CO = 0 when the shift amount is 0.
- OVF = 0.
- ASR replicates A[W-1].
REQ-013 MUL flags: OVF = 1 if the upper W product bits are nonzero; CO = 0.
REQ-014 ADC and SBC use the CO flag value held at the accept edge.
REQ-015 Reserved opcodes: C = 0, N = 0, Z = 1, CO = 0, OVF = 0, ERR = 1; ERR = 0 for all other opcodes.
REQ-016 Flags, C and ERR update only on the transition into OUT, and are held until the next transition into OUT.
REQ-017 in_valid is ignored while not in IDLE; no request is queued.

Reset
REQ-018 rst_n low asynchronously forces:
- state = IDLE;
- C = 0, N = 0, Z = 0, CO = 0, OVF = 0, ERR = 0;
- out_valid = 0; in_ready = 1 once reset is released.
REQ-019 Reset during BUSY or OUT aborts the operation with no result transfer.

Structure
REQ-020 Package alu_pkg holds the opcode constants and the FSM state type.
REQ-021 Sub-module alu_core holds the combinational datapath (opcodes 0-10, 12-15 plus flag generation); the MUL sequencer and FSM live in seq_alu.

Verification
REQ-022 ADD A=0x7F B=0x01 -> C=0x80, N=1, OVF=1, CO=0, Z=0; out_valid in the cycle after accept.
REQ-023 SUB A-B, A=0x05 B=0x05 -> C=0x00, Z=1, CO=1; then SBC A=0x00 B=0x00 -> C=0x00, Z=1, CO=1.
REQ-024 ADD A=0xFF B=0x01 -> C=0x00, CO=1, Z=1; then ADC A=0x00 B=0x00 -> C=0x01, CO=0.
REQ-025 MUL A=0x10 B=0x11 -> C=0x10, OVF=1; out_valid first high 9 cycles after accept; in_ready=0 throughout.
REQ-026 Shifts and backpressure:
- ASR A=0x80 by 3 -> C=0xF0, N=1, CO=0.
- LSR A=0x81 by 1 -> C=0x40, CO=1.
- out_ready held 0 for 5 cycles -> C and flags stable, no new accept.
REQ-027 rst_n pulsed low during BUSY of MUL -> all outputs 0 immediately; in_ready=1 after release; the next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB_AB = 4'd1;
  localparam logic [3:0] OP_SUB_BA = 4'd2;
  localparam logic [3:0] OP_BTC    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_XNOR   = 4'd7;
  localparam logic [3:0] OP_LSL    = 4'd8;
  localparam logic [3:0] OP_LSR    = 4'd9;
  localparam logic [3:0] OP_ASR    = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;
  localparam logic [3:0] OP_ADC    = 4'd12;
  localparam logic [3:0] OP_SBC    = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_OUT
  } state_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return op >= 4'd14;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: every opcode except MUL, plus flag generation.
// MUL yields zero here; the sequencer in seq_alu produces its result.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  input  logic         carry_in,
  output logic [W-1:0] result,
  output logic         n,
  output logic         z,
  output logic         co,
  output logic         ovf,
  output logic         err
);

  localparam int SW = $clog2(W);

  logic [SW-1:0] sh;
  logic [W-1:0]  add_x;
  logic [W-1:0]  add_y;
  logic          add_cin;
  logic [W:0]    sum;
  logic [W:0]    lsl_ext;
  logic [W:0]    lsr_ext;
  logic [W:0]    asr_ext;

  assign sh = b[SW-1:0];

  // All add/subtract opcodes share one adder; subtraction is X + ~Y + cin.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    case (op)
      OP_SUB_AB: begin add_y = ~b; add_cin = 1'b1; end
      OP_SUB_BA: begin add_x = b; add_y = ~a; add_cin = 1'b1; end
      OP_ADC:    add_cin = carry_in;
      OP_SBC:    begin add_y = ~b; add_cin = carry_in; end
      default:   ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  // The extra bit on each shift catches the last bit shifted out (0 for sh == 0).
  assign lsl_ext = {1'b0, a} << sh;
  assign lsr_ext = {a, 1'b0} >> sh;
  assign asr_ext = $unsigned($signed({a, 1'b0}) >>> sh);

  always_comb begin
    result = '0;
    co     = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD, OP_SUB_AB, OP_SUB_BA, OP_ADC, OP_SBC: begin
        result = sum[W-1:0];
        co     = sum[W];
        ovf    = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);
      end
      OP_BTC:  result = a & ~b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_LSL:  begin result = lsl_ext[W-1:0]; co = lsl_ext[W]; end
      OP_LSR:  begin result = lsr_ext[W:1];   co = lsr_ext[0]; end
      OP_ASR:  begin result = asr_ext[W:1];   co = asr_ext[0]; end
      default: err = is_reserved(op);
    endcase
    n = result[W-1];
    z = (result == '0);
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready request and result handshakes, a W-cycle
// shift-add multiplier, and registered result/flags held until the next result.
module seq_alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   CONTROL,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] C,
  output logic         N,
  output logic         Z,
  output logic         CO,
  output logic         OVF,
  output logic         ERR
);

  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);

  state_t          state_reg, state_next;
  logic [2*W-1:0]  mcand_reg;
  logic [2*W-1:0]  acc_reg;
  logic [2*W-1:0]  acc_next;
  logic [W-1:0]    mplier_reg;
  logic [SW-1:0]   cnt_reg;
  logic            accept;

  logic [W-1:0]    core_result;
  logic            core_n, core_z, core_co, core_ovf, core_err;

  alu_core #(.W(W)) u_core (
    .a        (A),
    .b        (B),
    .op       (CONTROL),
    .carry_in (CO),
    .result   (core_result),
    .n        (core_n),
    .z        (core_z),
    .co       (core_co),
    .ovf      (core_ovf),
    .err      (core_err)
  );

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_OUT);
  assign accept    = in_valid && in_ready;
  assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = (CONTROL == OP_MUL) ? ST_BUSY : ST_OUT;
      ST_BUSY: if (cnt_reg == CNT_LAST) state_next = ST_OUT;
      ST_OUT:  if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Result registers load only on entry to OUT; MUL loads on its final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      C          <= '0;
      N          <= 1'b0;
      Z          <= 1'b0;
      CO         <= 1'b0;
      OVF        <= 1'b0;
      ERR        <= 1'b0;
    end else if (accept) begin
      if (CONTROL == OP_MUL) begin
        mcand_reg  <= {{W{1'b0}}, A};
        mplier_reg <= B;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else begin
        C   <= core_result;
        N   <= core_n;
        Z   <= core_z;
        CO  <= core_co;
        OVF <= core_ovf;
        ERR <= core_err;
      end
    end else if (state_reg == ST_BUSY) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (cnt_reg == CNT_LAST) begin
        C   <= acc_next[W-1:0];
        N   <= acc_next[W-1];
        Z   <= (acc_next[W-1:0] == '0);
        CO  <= 1'b0;
        OVF <= (acc_next[2*W-1:W] != '0);
        ERR <= 1'b0;
      end
    end
  end

endmodule
